// File: rtl/spi_regfile_pkg.sv
// Shared types and width defaults for the SPI register-file arbiter.
package spi_regfile_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_SPI = 1'b0,
    OWN_LOC = 1'b1
  } owner_e;

endpackage

// File: rtl/spi_req_latch.sv
// One-deep capture of SPI wr/rd strobes; strobes that cannot be held are
// discarded and reported on a one-cycle drop pulse.
module spi_req_latch
  import spi_regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clear,
  output logic              full,
  output logic              req_we,
  output logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_wdata,
  output logic              drop
);

  logic strobe;
  logic capture;

  assign strobe  = wr | rd;
  // A slot being freed on this edge can take the new strobe straight away.
  assign capture = strobe && (!full || clear);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full      <= 1'b0;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      drop      <= 1'b0;
    end else begin
      drop <= strobe && ((full && !clear) || (wr && rd));
      if (capture) begin
        full      <= 1'b1;
        req_we    <= wr;
        req_addr  <= addr;
        req_wdata <= wdata;
      end else if (clear) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/spi_regfile_arbiter.sv
// Arbitrates one single-port register RAM between SPI (strict priority) and a
// local req/ack port, sequencing each access and returning read data.
module spi_regfile_arbiter
  import spi_regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_wr,
  input  logic              spi_rd,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic [DATA_W-1:0] spi_wdata,
  output logic [DATA_W-1:0] spi_rdata,
  output logic              spi_rvalid,
  output logic              spi_drop,
  input  logic              loc_req,
  input  logic              loc_we,
  input  logic [ADDR_W-1:0] loc_addr,
  input  logic [DATA_W-1:0] loc_wdata,
  output logic              loc_ack,
  output logic [DATA_W-1:0] loc_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state;
  owner_e            owner;
  logic              lat_full;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              spi_clear;
  logic              loc_grant_ok;

  assign spi_clear = (state == ISSUE) && (owner == OWN_SPI);
  // An SPI strobe arriving this edge wins the tie, and a request whose ack is
  // still showing is the one just served, not a new one.
  assign loc_grant_ok = loc_req && !loc_ack && !(spi_wr || spi_rd);

  spi_req_latch #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_latch (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr       (spi_wr),
    .rd       (spi_rd),
    .addr     (spi_addr),
    .wdata    (spi_wdata),
    .clear    (spi_clear),
    .full     (lat_full),
    .req_we   (lat_we),
    .req_addr (lat_addr),
    .req_wdata(lat_wdata),
    .drop     (spi_drop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= OWN_SPI;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      spi_rdata  <= '0;
      spi_rvalid <= 1'b0;
      loc_rdata  <= '0;
      loc_ack    <= 1'b0;
    end else begin
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      spi_rvalid <= 1'b0;
      loc_ack    <= 1'b0;
      case (state)
        IDLE: begin
          if (lat_full) begin
            state     <= ISSUE;
            owner     <= OWN_SPI;
            mem_en    <= 1'b1;
            mem_we    <= lat_we;
            mem_addr  <= lat_addr;
            mem_wdata <= lat_wdata;
          end else if (loc_grant_ok) begin
            state     <= ISSUE;
            owner     <= OWN_LOC;
            mem_en    <= 1'b1;
            mem_we    <= loc_we;
            mem_addr  <= loc_addr;
            mem_wdata <= loc_wdata;
          end
        end
        ISSUE: begin
          if (mem_we) begin
            state <= IDLE;
            if (owner == OWN_LOC) loc_ack <= 1'b1;
          end else begin
            state <= RDWAIT;
          end
        end
        RDWAIT: begin
          state <= IDLE;
          if (owner == OWN_SPI) begin
            spi_rdata  <= mem_rdata;
            spi_rvalid <= 1'b1;
          end else begin
            loc_rdata <= mem_rdata;
            loc_ack   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_regfile_arbiter.sv
// Scoreboard bench for spi_regfile_arbiter: directed SPI/local traffic against a
// behavioural 128x8 RAM, with expected events queued and checked by a monitor.
module tb_spi_regfile_arbiter;

  typedef struct {
    logic       we;
    logic [6:0] addr;
    logic [7:0] wdata;
    int         cyc;
  } mem_exp_t;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } spi_exp_t;

  typedef struct {
    logic       rd;
    logic [7:0] data;
    int         cyc;
  } loc_exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       spi_wr, spi_rd;
  logic [6:0] spi_addr;
  logic [7:0] spi_wdata;
  logic [7:0] spi_rdata;
  logic       spi_rvalid, spi_drop;
  logic       loc_req, loc_we;
  logic [6:0] loc_addr;
  logic [7:0] loc_wdata;
  logic       loc_ack;
  logic [7:0] loc_rdata;
  logic       mem_en, mem_we;
  logic [6:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  logic [7:0] ram [0:127];

  int cyc = 0;
  int compared = 0;
  int mismatched = 0;
  logic mem_track = 1'b1;
  logic prev_mem_en = 1'b0;
  logic loc_done;

  mem_exp_t mem_q [$];
  spi_exp_t spi_q [$];
  loc_exp_t loc_q [$];
  int       drop_q [$];

  mem_exp_t me;
  spi_exp_t se;
  loc_exp_t le;
  int       de;

  spi_regfile_arbiter #(.ADDR_W(7), .DATA_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_wr    (spi_wr),
    .spi_rd    (spi_rd),
    .spi_addr  (spi_addr),
    .spi_wdata (spi_wdata),
    .spi_rdata (spi_rdata),
    .spi_rvalid(spi_rvalid),
    .spi_drop  (spi_drop),
    .loc_req   (loc_req),
    .loc_we    (loc_we),
    .loc_addr  (loc_addr),
    .loc_wdata (loc_wdata),
    .loc_ack   (loc_ack),
    .loc_rdata (loc_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: event seen, none expected (cyc %0d)", name, cyc);
  endtask

  // Monitor: every DUT output event pops its expectation from the matching queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_en) check("mem_en_back_to_back", prev_mem_en, 0);
      if (mem_we) check("mem_we_without_en", mem_en, 1);
      if (mem_en && mem_track) begin
        if (mem_q.size() == 0) unexpected("mem_access");
        else begin
          me = mem_q.pop_front();
          check("mem_we", mem_we, me.we);
          check("mem_addr", mem_addr, me.addr);
          if (me.we) check("mem_wdata", mem_wdata, me.wdata);
          if (me.cyc >= 0) check("mem_en_cycle", cyc, me.cyc);
        end
      end
      if (spi_rvalid) begin
        if (spi_q.size() == 0) unexpected("spi_rvalid");
        else begin
          se = spi_q.pop_front();
          check("spi_rdata", spi_rdata, se.data);
          if (se.cyc >= 0) check("spi_rvalid_cycle", cyc, se.cyc);
        end
      end
      if (loc_ack) begin
        if (loc_q.size() == 0) unexpected("loc_ack");
        else begin
          le = loc_q.pop_front();
          if (le.rd) check("loc_rdata", loc_rdata, le.data);
          if (le.cyc >= 0) check("loc_ack_cycle", cyc, le.cyc);
        end
      end
      if (spi_drop) begin
        if (drop_q.size() == 0) unexpected("spi_drop");
        else begin
          de = drop_q.pop_front();
          check("spi_drop_cycle", cyc, de);
        end
      end
    end
    prev_mem_en = rst_n ? mem_en : 1'b0;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_en"}, mem_en, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_spi_rdata"}, spi_rdata, 0);
    check({tag, "_spi_rvalid"}, spi_rvalid, 0);
    check({tag, "_spi_drop"}, spi_drop, 0);
    check({tag, "_loc_ack"}, loc_ack, 0);
    check({tag, "_loc_rdata"}, loc_rdata, 0);
  endtask

  task automatic wait_ack();
    logic got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (loc_ack) begin
        got = 1'b1;
        break;
      end
    end
    loc_req = 1'b0;
    if (!got) check("loc_ack_timeout", 0, 1);
  endtask

  task automatic loc_access(input logic we, input logic [6:0] a, input logic [7:0] d,
                            input logic [7:0] exp_rd);
    step();
    loc_q.push_back('{!we, exp_rd, -1});
    loc_req = 1'b1; loc_we = we; loc_addr = a; loc_wdata = d;
    wait_ack();
  endtask

  function automatic logic [7:0] pattern(input int a);
    logic [7:0] v;
    v = a[7:0];
    return v ^ 8'h39;
  endfunction

  initial begin
    int n;
    rst_n = 1'b0;
    spi_wr = 0; spi_rd = 0; spi_addr = '0; spi_wdata = '0;
    loc_req = 0; loc_we = 0; loc_addr = '0; loc_wdata = '0;
    idle(2);
    check_all_zero("reset");
    rst_n = 1'b1;
    idle(2);

    $display("[TB] SPI write 0x05<-0xA5 then SPI read 0x05");
    step(); n = cyc + 1;
    mem_q.push_back('{1'b1, 7'h05, 8'hA5, n + 1});
    spi_wr = 1; spi_addr = 7'h05; spi_wdata = 8'hA5;
    step(); spi_wr = 0;
    idle(6);
    n = cyc + 1;
    mem_q.push_back('{1'b0, 7'h05, 8'h00, n + 1});
    spi_q.push_back('{8'hA5, n + 3});
    spi_rd = 1;
    step(); spi_rd = 0;
    idle(6);

    $display("[TB] Local read and SPI write 0x05<-0x3C in the same cycle");
    n = cyc + 1;
    mem_q.push_back('{1'b1, 7'h05, 8'h3C, n + 1});
    mem_q.push_back('{1'b0, 7'h05, 8'h00, n + 3});
    loc_q.push_back('{1'b1, 8'h3C, n + 5});
    spi_wr = 1; spi_addr = 7'h05; spi_wdata = 8'h3C;
    loc_req = 1; loc_we = 0; loc_addr = 7'h05;
    step(); spi_wr = 0;
    wait_ack();
    idle(4);

    $display("[TB] Three SPI strobes during a local read");
    n = cyc + 1;
    mem_q.push_back('{1'b0, 7'h05, 8'h00, n});
    loc_q.push_back('{1'b1, 8'h3C, n + 2});
    mem_q.push_back('{1'b1, 7'h20, 8'h11, n + 3});
    loc_req = 1; loc_we = 0; loc_addr = 7'h05;
    step();
    spi_wr = 1; spi_addr = 7'h20; spi_wdata = 8'h11;
    step();
    drop_q.push_back(n + 2);
    spi_wr = 0; spi_rd = 1; spi_addr = 7'h21;
    step();
    drop_q.push_back(n + 3);
    spi_rd = 0; spi_wr = 1; spi_addr = 7'h22; spi_wdata = 8'h33;
    if (loc_ack) loc_req = 0;
    step();
    spi_wr = 0;
    if (loc_req) wait_ack();
    idle(6);

    $display("[TB] SPI wr and rd together at 0x10");
    n = cyc + 1;
    drop_q.push_back(n);
    mem_q.push_back('{1'b1, 7'h10, 8'h5A, n + 1});
    spi_wr = 1; spi_rd = 1; spi_addr = 7'h10; spi_wdata = 8'h5A;
    step(); spi_wr = 0; spi_rd = 0;
    idle(6);
    n = cyc + 1;
    mem_q.push_back('{1'b0, 7'h10, 8'h00, n + 1});
    spi_q.push_back('{8'h5A, n + 3});
    spi_rd = 1;
    step(); spi_rd = 0;
    idle(6);

    $display("[TB] Reset asserted during RDWAIT of a local read");
    n = cyc + 1;
    mem_q.push_back('{1'b0, 7'h10, 8'h00, n});
    loc_req = 1; loc_we = 0; loc_addr = 7'h10;
    step();
    step();
    rst_n = 1'b0; loc_req = 0;
    #1;
    check_all_zero("midreset");
    idle(2);
    rst_n = 1'b1;
    idle(8);

    $display("[TB] Local writes 0x00..0x7F with periodic SPI reads");
    mem_track = 1'b0;
    loc_done = 1'b0;
    fork
      begin
        for (int a = 0; a < 128; a++) loc_access(1'b1, a[6:0], pattern(a), 8'h00);
        loc_done = 1'b1;
      end
      begin
        while (!loc_done) begin
          idle(16);
          if (loc_done) break;
          spi_q.push_back('{8'h3C, -1});
          spi_rd = 1; spi_addr = 7'h05;
          step(); spi_rd = 0;
        end
      end
    join
    idle(6);
    for (int a = 0; a < 128; a++) loc_access(1'b0, a[6:0], 8'h00, pattern(a));
    idle(10);

    check("mem_q_drained", mem_q.size(), 0);
    check("spi_q_drained", spi_q.size(), 0);
    check("loc_q_drained", loc_q.size(), 0);
    check("drop_q_drained", drop_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
